// File: rtl/cal_pkg.sv
// Shared calendar constants: per-field upper limits, default widths and the range-check result payload.
package cal_pkg;

   localparam int unsigned SEC_MAX = 59;
   localparam int unsigned MIN_MAX = 59;
   localparam int unsigned HR_MAX  = 23;
   localparam int unsigned DAY_MAX = 31;
   localparam int unsigned MON_MAX = 12;

   localparam int unsigned SEC_WIDTH = 6;
   localparam int unsigned MIN_WIDTH = 6;
   localparam int unsigned HR_WIDTH  = 5;
   localparam int unsigned DAY_WIDTH = 5;
   localparam int unsigned MON_WIDTH = 4;

   typedef struct packed {
      logic in_range;
      logic at_max;
      logic at_min;
      logic above_max;
   } range_t;

endpackage

// File: rtl/cal_range_check.sv
// Classifies a value against the legal window [MIN_VAL, lim].
module cal_range_check
   import cal_pkg::*;
#(
   parameter int unsigned WIDTH   = MON_WIDTH,
   parameter int unsigned MIN_VAL = 1
) (
   input  logic [WIDTH-1:0] val,
   input  logic [WIDTH-1:0] lim,
   output range_t           rc
);

   localparam logic [WIDTH-1:0] LO_VAL = WIDTH'(MIN_VAL);

   logic above;

   assign above = (val > lim);

   always_comb begin
      rc           = '0;
      rc.above_max = above;
      rc.at_max    = (val == lim);
      rc.at_min    = (val == LO_VAL);
      rc.in_range  = (val >= LO_VAL) && !above;
   end

endmodule

// File: rtl/cal_field_counter.sv
// One calendar field: wrapping up/down counter with checked parallel load and optional runtime limit.
module cal_field_counter
   import cal_pkg::*;
#(
   parameter int unsigned WIDTH   = MON_WIDTH,
   parameter int unsigned MIN_VAL = 1,
   parameter int unsigned MAX_VAL = MON_MAX,
   parameter int unsigned DYN_MAX = 0
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             tick,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] max_val,
   input  logic             enable,
   output logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] databus,
   output logic             carry,
   output logic             borrow,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] LO_VAL = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] HI_VAL = WIDTH'(MAX_VAL);
   localparam logic             DYN    = (DYN_MAX != 0);

   logic [WIDTH-1:0] lim;
   logic             lim_bad;
   logic             clamp;
   range_t           rc_val;
   range_t           rc_data;
   logic             data_unused;

   logic [WIDTH-1:0] value_nxt;
   logic             carry_nxt;
   logic             borrow_nxt;
   logic             load_err_nxt;

   assign lim     = DYN ? max_val : HI_VAL;
   assign lim_bad = DYN && (max_val < LO_VAL);
   assign clamp   = DYN && rc_val.above_max;

   cal_range_check #(.WIDTH(WIDTH), .MIN_VAL(MIN_VAL)) u_rc_val (
      .val (value),
      .lim (lim),
      .rc  (rc_val)
   );

   cal_range_check #(.WIDTH(WIDTH), .MIN_VAL(MIN_VAL)) u_rc_data (
      .val (data),
      .lim (lim),
      .rc  (rc_data)
   );

   // Only the window test matters for load data.
   assign data_unused = ^{rc_data.at_max, rc_data.at_min, rc_data.above_max, rc_val.in_range};

   // Priority: illegal limit, load, clamp, tick.
   always_comb begin
      value_nxt    = value;
      carry_nxt    = 1'b0;
      borrow_nxt   = 1'b0;
      load_err_nxt = 1'b0;
      if (lim_bad) begin
         value_nxt    = LO_VAL;
         load_err_nxt = load;
      end else if (load) begin
         if (rc_data.in_range) begin
            value_nxt = data;
         end else begin
            load_err_nxt = 1'b1;
         end
      end else if (clamp) begin
         value_nxt = lim;
      end else if (tick) begin
         if (up_down) begin
            if (rc_val.at_max) begin
               value_nxt = LO_VAL;
               carry_nxt = 1'b1;
            end else begin
               value_nxt = value + WIDTH'(1);
            end
         end else begin
            if (rc_val.at_min) begin
               value_nxt  = lim;
               borrow_nxt = 1'b1;
            end else begin
               value_nxt = value - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         value    <= LO_VAL;
         carry    <= 1'b0;
         borrow   <= 1'b0;
         load_err <= 1'b0;
      end else begin
         value    <= value_nxt;
         carry    <= carry_nxt;
         borrow   <= borrow_nxt;
         load_err <= load_err_nxt;
      end
   end

   assign databus = enable ? value : '0;

endmodule
